// File: rtl/debouncer_multi.sv
// debouncer_multi
// Multi-channel switch debouncer. Each channel has a 2FF synchroniser, a
// sample register and an up/down averaging counter. A new level is committed
// after 2^N_THRESH cycles of net disagreement. Each channel has its own
// pull-up/pull-down polarity and emits one-cycle press and release pulses.
// Optional feature: define DEBOUNCER_LONGPRESS_EN to enable a per-channel
// long-press detector. It fires once after the channel has been held ON for
// 2^N_LONG - 1 cycles. Without the macro, o_long_press is tied low.
module debouncer_multi #(
  parameter int              N_CH        = 4,
  parameter int              N_THRESH    = 3,
  parameter logic [N_CH-1:0] PULLUP_MASK = '0,
  parameter int              N_LONG      = 10
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [N_CH-1:0] i_sig,
  output logic [N_CH-1:0] o_sig_debounced,
  output logic [N_CH-1:0] o_press,
  output logic [N_CH-1:0] o_release,
  output logic [N_CH-1:0] o_long_press
);

  // Counter value at which a persisting disagreement is committed.
  localparam logic [N_THRESH:0] CNT_MAX = {1'b0, {N_THRESH{1'b1}}};
  localparam logic [N_THRESH:0] CNT_ONE = {{N_THRESH{1'b0}}, 1'b1};

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic              meta;
    logic              sync;
    logic              sig;
    logic              deb;
    logic [N_THRESH:0] cnt;
    logic              press;
    logic              rel;
    logic              commit;
    logic              sig_on;

    // A commit happens when the sample still disagrees with the debounced
    // level and the counter has reached its threshold.
    assign commit = (sig != deb) && (cnt == CNT_MAX);
    // The level being committed is ON when it differs from the idle (pull) level.
    assign sig_on = sig ^ PULLUP_MASK[i];

    // Synchroniser and sample pipeline. These registers reset to the idle
    // level, so leaving reset never looks like an edge.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        meta <= PULLUP_MASK[i];
        sync <= PULLUP_MASK[i];
        sig  <= PULLUP_MASK[i];
      end else begin
        // NOTE: non-blocking assignments let each stage see the previous stage's
        // old value, so this forms a real three-flop chain rather than a wire.
        meta <= i_sig[i];
        sync <= meta;
        sig  <= sync;
      end
    end

    // Up/down averaging counter and debounced level.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        deb <= PULLUP_MASK[i];
        cnt <= '0;
      end else if (sig != deb) begin
        if (cnt == CNT_MAX) begin
          deb <= sig;
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_ONE;
        end
      end else if (cnt != '0) begin
        cnt <= cnt - CNT_ONE;
      end
    end

    // Press/release event pulses, raised on the same edge that deb changes.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        press <= 1'b0;
        rel   <= 1'b0;
      end else begin
        press <= commit && sig_on;
        rel   <= commit && !sig_on;
      end
    end

    assign o_sig_debounced[i] = deb;
    assign o_press[i]         = press;
    assign o_release[i]       = rel;

`ifdef DEBOUNCER_LONGPRESS_EN
    localparam logic [N_LONG-1:0] HCNT_MAX = {N_LONG{1'b1}};
    localparam logic [N_LONG-1:0] HCNT_ONE = {{(N_LONG-1){1'b0}}, 1'b1};
    localparam logic [N_LONG-1:0] HCNT_ARM = HCNT_MAX - HCNT_ONE;

    logic [N_LONG-1:0] hcnt;
    logic              long_press;
    logic              deb_on;

    assign deb_on = deb ^ PULLUP_MASK[i];

    // Hold counter. It saturates at its maximum, so each press gives exactly
    // one long-press pulse. Releasing clears it and re-arms the detector.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        hcnt       <= '0;
        long_press <= 1'b0;
      end else begin
        long_press <= deb_on && (hcnt == HCNT_ARM);
        if (!deb_on) begin
          hcnt <= '0;
        end else if (hcnt != HCNT_MAX) begin
          hcnt <= hcnt + HCNT_ONE;
        end
      end
    end

    assign o_long_press[i] = long_press;
`else
    assign o_long_press[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_debouncer_multi.sv
// tb_debouncer_multi
// Scoreboarded bench for debouncer_multi. A driver applies inputs on the
// falling edge. It advances a behavioural model and queues the expected outputs
// for the next rising edge. A monitor pops and compares after each rising edge.
// Directed latency checks and randomized burst stimulus follow.
// When DEBOUNCER_LONGPRESS_EN is defined, the long-press expectations are enabled.
module tb_debouncer_multi;

  localparam int         N_CH     = 2;
  localparam int         N_THRESH = 3;
  localparam logic [1:0] P        = 2'b10;
  localparam int         N_LONG   = 4;
  localparam int         TH       = 1 << N_THRESH;
  localparam int         LONG_MAX = (1 << N_LONG) - 1;
  localparam logic [1:0] IDLE     = P;

  typedef struct packed {
    logic [1:0] deb;
    logic [1:0] press;
    logic [1:0] rel;
    logic [1:0] lng;
  } exp_t;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic [1:0] i_sig = IDLE;
  logic [1:0] o_sig_debounced;
  logic [1:0] o_press;
  logic [1:0] o_release;
  logic [1:0] o_long_press;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t       exp_q[$];
  logic [1:0] hist[$];
  logic [1:0] m_deb;
  int         m_cnt[2];
  int         m_hcnt[2];

  logic [1:0] obs_deb, obs_press, obs_rel, obs_long;
  int         n_press[2], n_rel[2], n_long[2];

  debouncer_multi #(
    .N_CH(N_CH), .N_THRESH(N_THRESH), .PULLUP_MASK(P), .N_LONG(N_LONG)
  ) dut (
    .clk(clk), .rstn(rstn), .i_sig(i_sig),
    .o_sig_debounced(o_sig_debounced), .o_press(o_press),
    .o_release(o_release), .o_long_press(o_long_press)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the input history queue gives the value the sampler holds.
  // The debounced level follows the net-disagreement rule. Events are derived
  // from level changes.
  task automatic model_reset(output exp_t e);
    hist = {P, P, P};
    m_deb = P;
    for (int ch = 0; ch < 2; ch++) begin
      m_cnt[ch]  = 0;
      m_hcnt[ch] = 0;
    end
    e = '{deb: P, press: 2'b00, rel: 2'b00, lng: 2'b00};
  endtask

  task automatic model_edge(input logic [1:0] raw, output exp_t e);
    logic [1:0] s_old;
    logic [1:0] deb_old;
    s_old = hist.pop_front();
    hist.push_back(raw);
    deb_old = m_deb;
    e = '{deb: 2'b00, press: 2'b00, rel: 2'b00, lng: 2'b00};
    for (int ch = 0; ch < 2; ch++) begin
`ifdef DEBOUNCER_LONGPRESS_EN
      if (deb_old[ch] == P[ch]) m_hcnt[ch] = 0;
      else if (m_hcnt[ch] < LONG_MAX) begin
        m_hcnt[ch]++;
        if (m_hcnt[ch] == LONG_MAX) e.lng[ch] = 1'b1;
      end
`endif
      if (s_old[ch] != deb_old[ch]) begin
        if (m_cnt[ch] == TH - 1) begin
          m_deb[ch] = s_old[ch];
          m_cnt[ch] = 0;
          if (s_old[ch] != P[ch]) e.press[ch] = 1'b1;
          else                    e.rel[ch]   = 1'b1;
        end else begin
          m_cnt[ch]++;
        end
      end else if (m_cnt[ch] > 0) begin
        m_cnt[ch]--;
      end
    end
    e.deb = m_deb;
  endtask

  // One cycle: observe the previous edge's outputs, drive new inputs, and
  // queue the expectation for the coming rising edge.
  task automatic cyc(input logic [1:0] v, input logic r);
    exp_t e;
    @(negedge clk);
    obs_deb   = o_sig_debounced;
    obs_press = o_press;
    obs_rel   = o_release;
    obs_long  = o_long_press;
    for (int ch = 0; ch < 2; ch++) begin
      if (obs_press[ch]) n_press[ch]++;
      if (obs_rel[ch])   n_rel[ch]++;
      if (obs_long[ch])  n_long[ch]++;
    end
    rstn  = r;
    i_sig = v;
    if (!r) model_reset(e);
    else    model_edge(v, e);
    exp_q.push_back(e);
  endtask

  task automatic clear_counts();
    for (int ch = 0; ch < 2; ch++) begin
      n_press[ch] = 0;
      n_rel[ch]   = 0;
      n_long[ch]  = 0;
    end
  endtask

  // Holds v and reports the edge offset at which the selected pulse first
  // appears (kind: 0 press, 1 release, 2 long). The wait is bounded.
  task automatic wait_pulse(input string name, input int ch, input int kind,
                            input logic [1:0] v, input int exp_k, input int bound);
    int   found;
    logic hit;
    found = 0;
    for (int k = 1; k <= bound && found == 0; k++) begin
      cyc(v, 1'b1);
      case (kind)
        0:       hit = obs_press[ch];
        1:       hit = obs_rel[ch];
        default: hit = obs_long[ch];
      endcase
      if (hit) found = k;
    end
    check(name, found, exp_k);
  endtask

  // Monitor: compare each rising edge's outputs with the queued expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("deb",     int'(o_sig_debounced), int'(e.deb));
      check("press",   int'(o_press),         int'(e.press));
      check("release", int'(o_release),       int'(e.rel));
      check("long",    int'(o_long_press),    int'(e.lng));
    end
  end

  initial begin
    int         rem[2];
    logic [1:0] val;

    // Reset while the inputs are driven to 2'b01.
    for (int c = 0; c < 4; c++) cyc(2'b01, 1'b0);
    #1;
    check("reset_deb",   int'(o_sig_debounced), int'(P));
    check("reset_press", int'(o_press | o_release | o_long_press), 0);
    clear_counts();
    for (int c = 0; c < 10; c++) cyc(2'b01, 1'b1);
    check("post_reset_press0", n_press[0], 0);
    for (int c = 0; c < 2; c++) cyc(IDLE, 1'b0);
    for (int c = 0; c < 5; c++) cyc(IDLE, 1'b1);

    // Channel 0 press latency, long press, and release latency.
    clear_counts();
    cyc(2'b11, 1'b1);
    wait_pulse("press0_latency", 0, 0, 2'b11, 11, 20);
    check("press0_level", int'(obs_deb), 2'b11);
`ifdef DEBOUNCER_LONGPRESS_EN
    wait_pulse("long0_latency", 0, 2, 2'b11, LONG_MAX, 30);
    for (int c = 0; c < 30; c++) cyc(2'b11, 1'b1);
    check("long0_once", n_long[0], 1);
`else
    for (int c = 0; c < 45; c++) cyc(2'b11, 1'b1);
    check("long0_absent", n_long[0], 0);
`endif
    check("press0_once", n_press[0], 1);
    cyc(IDLE, 1'b1);
    wait_pulse("release0_latency", 0, 1, IDLE, 11, 20);

    // Single-cycle toggling never commits. A 6-high/2-low burst pattern does.
    for (int c = 0; c < 20; c++) cyc(IDLE, 1'b1);
    clear_counts();
    for (int c = 0; c < 100; c++) cyc({1'b1, 1'(c % 2)}, 1'b1);
    check("toggle_no_press", n_press[0] + n_rel[0], 0);
    for (int c = 0; c < 96; c++) cyc({1'b1, 1'((c % 8) < 6)}, 1'b1);
    check("burst_press_once", n_press[0], 1);
    check("burst_no_release", n_rel[0], 0);
    for (int c = 0; c < 20; c++) cyc(IDLE, 1'b1);

    // Pull-up channel 1: ON is low.
    clear_counts();
    cyc(2'b00, 1'b1);
    wait_pulse("press1_latency", 1, 0, 2'b00, 11, 20);
    check("press1_level", int'(obs_deb), 2'b00);
    for (int c = 0; c < 10; c++) cyc(2'b00, 1'b1);
    cyc(IDLE, 1'b1);
    wait_pulse("release1_latency", 1, 1, IDLE, 11, 20);
    check("ch0_untouched", n_press[0] + n_rel[0], 0);

    // Reset asserted mid-count, while the counter is at 5 toward a release.
    for (int c = 0; c < 20; c++) cyc(IDLE, 1'b1);
    cyc(2'b11, 1'b1);
    for (int c = 0; c < 20; c++) cyc(2'b11, 1'b1);
    for (int c = 0; c < 8; c++) cyc(IDLE, 1'b1);
    cyc(2'b11, 1'b0);
    #1;
    check("midreset_deb",   int'(o_sig_debounced), int'(P));
    check("midreset_pulse", int'(o_press | o_release | o_long_press), 0);
    cyc(2'b11, 1'b0);
    cyc(2'b11, 1'b1);
    wait_pulse("press_after_reset", 0, 0, 2'b11, 11, 20);
    for (int c = 0; c < 20; c++) cyc(IDLE, 1'b1);

    // Randomized bursts, with occasional resets.
    val = IDLE;
    rem[0] = 0;
    rem[1] = 0;
    for (int c = 0; c < 2500; c++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (rem[ch] == 0) begin
          val[ch] = 1'($urandom_range(0, 1));
          rem[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                : int'($urandom_range(4, 24));
        end
        rem[ch]--;
      end
      if ($urandom_range(0, 499) == 0) begin
        cyc(val, 1'b0);
        cyc(val, 1'b0);
      end else begin
        cyc(val, 1'b1);
      end
    end

    @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
